truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner.sv | 147 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Walks {a,b,c} through all eight vectors, samples y_in after a settle delay and
// compares the captured truth table against an expected one. Optional MISMATCH_COUNT_EN adds mism_cnt.
module truth_table_scanner #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] exp_tbl,
  input  logic       y_in,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] tbl
`ifdef MISMATCH_COUNT_EN
  ,
  output logic [3:0] mism_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tbl_q, tbl_d;
  logic [7:0] exp_q, exp_d;
  logic       pass_q, pass_d;
  logic [7:0] tbl_smp;
  logic       sample_w;
  logic       last_w;
`ifdef MISMATCH_COUNT_EN
  logic [3:0] mism_q, mism_d;
`endif

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Abort takes priority over a sample on the same edge, including the final one.
  assign sample_w = (state_q == SETTLE) && !abort && (cnt_q == 4'(SETTLE_CYCLES));
  assign last_w   = sample_w && (idx_q == 3'd7);

  always_comb begin
    tbl_smp         = tbl_q;
    tbl_smp[idx_q]  = y_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      tbl_q   <= 8'd0;
      exp_q   <= 8'd0;
      pass_q  <= 1'b0;
`ifdef MISMATCH_COUNT_EN
      mism_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
`ifdef MISMATCH_COUNT_EN
      mism_q  <= mism_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE: begin
        if (abort)       state_d = IDLE;
        else if (last_w) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    tbl_d  = tbl_q;
    exp_d  = exp_q;
    pass_d = pass_q;
`ifdef MISMATCH_COUNT_EN
    mism_d = mism_q;
`endif
    if (state_q == IDLE && start) begin
      exp_d  = exp_tbl;
      tbl_d  = 8'd0;
      pass_d = 1'b0;
      idx_d  = 3'd0;
      cnt_d  = 4'd0;
`ifdef MISMATCH_COUNT_EN
      mism_d = 4'd0;
`endif
    end else if (state_q == SETTLE) begin
      if (abort) begin
        pass_d = 1'b0;
      end else if (sample_w) begin
        tbl_d = tbl_smp;
        cnt_d = 4'd0;
        if (last_w) begin
          pass_d = (tbl_smp == exp_q);
`ifdef MISMATCH_COUNT_EN
          mism_d = popcount8(tbl_smp ^ exp_q);
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    busy = (state_q == SETTLE);
    done = (state_q == DONE);
    {a_o, b_o, c_o} = busy ? idx_q : 3'b000;
  end

  assign pass = pass_q;
  assign tbl  = tbl_q;
`ifdef MISMATCH_COUNT_EN
  assign mism_cnt = mism_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE_CYCLES 1 and 4) share stimulus
// and are compared every cycle against a vector/phase-count reference model.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, use_fn;
  logic [7:0] exp_tbl, ftbl;
  logic       a1, b1, c1, busy1, done1, pass1, y1;
  logic       a4, b4, c4, busy4, done4, pass4, y4;
  logic [7:0] tbl1, tbl4;
  logic [3:0] mism1, mism4;

  assign y1 = use_fn ? ((~b1 & ~c1) | (a1 & ~b1)) : ftbl[{a1, b1, c1}];
  assign y4 = use_fn ? ((~b4 & ~c4) | (a4 & ~b4)) : ftbl[{a4, b4, c4}];

  truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tbl(exp_tbl), .y_in(y1),
    .a_o(a1), .b_o(b1), .c_o(c1), .busy(busy1), .done(done1), .pass(pass1), .tbl(tbl1)
`ifdef MISMATCH_COUNT_EN
    , .mism_cnt(mism1)
`endif
  );

  truth_table_scanner #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tbl(exp_tbl), .y_in(y4),
    .a_o(a4), .b_o(b4), .c_o(c4), .busy(busy4), .done(done4), .pass(pass4), .tbl(tbl4)
`ifdef MISMATCH_COUNT_EN
    , .mism_cnt(mism4)
`endif
  );

`ifndef MISMATCH_COUNT_EN
  assign mism1 = 4'd0;
  assign mism4 = 4'd0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: k = edges spent scanning, vector = k/(S+1), sample when k%(S+1)==S.
  int         sc[2] = '{1, 4};
  int         m_k[2];
  logic       m_act[2], m_done[2], m_pass[2];
  logic [7:0] m_tbl[2], m_exp[2];
  logic [3:0] m_mism[2];

  function automatic logic ref_y(input logic [2:0] v);
    if (use_fn) return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    return ftbl[v];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_k[d] = 0; m_act[d] = 0; m_done[d] = 0; m_pass[d] = 0;
      m_tbl[d] = 8'd0; m_exp[d] = 8'd0; m_mism[d] = 4'd0;
    end
  endtask

  task automatic model_edge(input int d);
    int v, ph;
    v  = m_k[d] / (sc[d] + 1);
    ph = m_k[d] % (sc[d] + 1);
    if (m_done[d]) begin
      m_done[d] = 0;
    end else if (m_act[d]) begin
      if (abort) begin
        m_act[d] = 0; m_pass[d] = 0;
      end else begin
        if (ph == sc[d]) begin
          m_tbl[d][v] = ref_y(v[2:0]);
          if (v == 7) begin
            m_act[d]  = 0;
            m_done[d] = 1;
            m_pass[d] = (m_tbl[d] == m_exp[d]);
            m_mism[d] = 4'($countones(m_tbl[d] ^ m_exp[d]));
          end
        end
        m_k[d]++;
      end
    end else if (start) begin
      m_act[d] = 1; m_k[d] = 0; m_exp[d] = exp_tbl;
      m_tbl[d] = 8'd0; m_pass[d] = 0; m_mism[d] = 4'd0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cmp_dut(input int d, input logic bsy, input logic dn, input logic [2:0] abc,
                         input logic ps, input logic [7:0] tb, input logic [3:0] mm);
    logic [2:0] e_abc;
    e_abc = m_act[d] ? 3'(m_k[d] / (sc[d] + 1)) : 3'd0;
    chk($sformatf("busy_s%0d", sc[d]), {31'd0, bsy}, {31'd0, m_act[d]});
    chk($sformatf("done_s%0d", sc[d]), {31'd0, dn}, {31'd0, m_done[d]});
    chk($sformatf("abc_s%0d", sc[d]), {29'd0, abc}, {29'd0, e_abc});
    chk($sformatf("pass_s%0d", sc[d]), {31'd0, ps}, {31'd0, m_pass[d]});
    chk($sformatf("tbl_s%0d", sc[d]), {24'd0, tb}, {24'd0, m_tbl[d]});
`ifdef MISMATCH_COUNT_EN
    chk($sformatf("mism_s%0d", sc[d]), {28'd0, mm}, {28'd0, m_mism[d]});
`endif
  endtask

  task automatic compare_all();
    cmp_dut(0, busy1, done1, {a1, b1, c1}, pass1, tbl1, mism1);
    cmp_dut(1, busy4, done4, {a4, b4, c4}, pass4, tbl4, mism4);
  endtask

  // One clock: model advances from the settled pre-edge inputs, DUT is checked after the edge.
  task automatic step();
    @(negedge clk);
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Start a scan and count edges (start edge = 1) until each instance shows done.
  task automatic timed_scan(input logic [7:0] et, output int n1, output int n4);
    int n;
    n1 = 0; n4 = 0;
    exp_tbl = et; start = 1'b1;
    step(); n = 1;
    start = 1'b0;
    while ((n1 == 0 || n4 == 0) && n < 100) begin
      exp_tbl = 8'($urandom);
      step(); n++;
      if (done1 && n1 == 0) n1 = n;
      if (done4 && n4 == 0) n4 = n;
    end
  endtask

  initial begin
    int n1, n4, n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tbl = 8'd0; use_fn = 1'b0; ftbl = 8'd0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;
    step();

    // Correct function
    use_fn = 1'b1;
    timed_scan(8'h31, n1, n4);
    chk("done_lat_s1", n1, 17);
    chk("done_lat_s4", n4, 41);
    chk("good_tbl", {24'd0, tbl1}, 32'h31);
    chk("good_pass", {31'd0, pass1}, 32'd1);
    chk("good_tbl_s4", {24'd0, tbl4}, 32'h31);
`ifdef MISMATCH_COUNT_EN
    chk("good_mism", {28'd0, mism1}, 32'd0);
`endif
    step();

    // Faulty function: y stuck at 0
    use_fn = 1'b0; ftbl = 8'h00;
    timed_scan(8'h31, n1, n4);
    chk("bad_tbl", {24'd0, tbl1}, 32'h00);
    chk("bad_pass", {31'd0, pass1}, 32'd0);
`ifdef MISMATCH_COUNT_EN
    chk("bad_mism", {28'd0, mism1}, 32'd3);
`endif
    step(); step();

    // Abort at vector 3
    ftbl = 8'hFF; exp_tbl = 8'h5A; start = 1'b1;
    step(); start = 1'b0;
    n = 0;
    while ({a1, b1, c1} != 3'd3 && n < 50) begin step(); n++; end
    chk("abort_reach_idx3", {29'd0, a1, b1, c1}, 32'd3);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_done", {31'd0, done1}, 32'd0);
    chk("abort_tbl_hi", {27'd0, tbl1[7:3]}, 32'd0);
    chk("abort_tbl_lo", {29'd0, tbl1[2:0]}, 32'd7);
    for (int i = 0; i < 4; i++) step();

    // Abort on the final sample edge
    ftbl = 8'($urandom); start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_last_done", {31'd0, done1}, 32'd0);
    chk("abort_last_busy", {31'd0, busy1}, 32'd0);
    step();
    chk("abort_last_nodone", {31'd0, done1}, 32'd0);
    for (int i = 0; i < 30; i++) step();

    // Asynchronous reset mid-scan
    ftbl = 8'($urandom); start = 1'b1;
    step(); start = 1'b0;
    n = 0;
    while ({a1, b1, c1} != 3'd5 && n < 50) begin step(); n++; end
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    chk("rst_tbl", {24'd0, tbl1}, 32'd0);
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("rst_restart_abc", {29'd0, a1, b1, c1}, 32'd0);
    chk("rst_restart_busy", {31'd0, busy1}, 32'd1);
    for (int i = 0; i < 45; i++) step();

    // Held start: back-to-back scans with one IDLE cycle between them
    start = 1'b1;
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (!done1 && n < 40) begin step(); n++; end
      chk("held_done_seen", {31'd0, done1}, 32'd1);
      step();
      chk("held_idle_gap", {30'd0, busy1, done1}, 32'd0);
      step();
      chk("held_restart", {31'd0, busy1}, 32'd1);
    end
    start = 1'b0;
    for (int i = 0; i < 45; i++) step();

    // Randomized traffic: stray starts, occasional aborts, changing tables
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 5) == 0);
      abort   = ($urandom_range(0, 60) == 0);
      exp_tbl = 8'($urandom);
      use_fn  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 20) == 0) ftbl = 8'($urandom);
      step();
    end
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 45; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
